// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART transmitter among N byte-stream requesters.
// A grant is held for a whole frame unless the burst or idle-hold limit forces a release.
//
// state | meaning
// IDLE  | no owner; pick next requester round-robin after ptr
// SEND  | owner granted; waiting for its next byte handshake
// WAIT  | byte written to the UART; waiting for tx_done
module uart_tx_arbiter #(
    parameter int N           = 4,
    parameter int MAX_BURST   = 16,
    parameter int HOLD_CYCLES = 255
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    input  logic [N-1:0]   req_valid,
    input  logic [8*N-1:0] req_data,
    input  logic [N-1:0]   req_last,
    output logic [N-1:0]   req_ready,
    output logic [N-1:0]   grant,
    output logic           busy,
    output logic [7:0]     tx_data,
    output logic           tx_wr,
    input  logic           tx_done
);

    localparam int IW = $clog2(N);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [N-1:0] ONE = 1;

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] owner;
    logic          last_q;
    logic [BW-1:0] burst_cnt;
    logic [HW-1:0] hold_cnt;
    logic [IW-1:0] pick;
    logic [IW-1:0] cand;
    logic          handshake;

    // Scan downward so the candidate closest to ptr+1 is the last one written.
    always_comb begin
        pick = '0;
        cand = '0;
        for (int k = N; k >= 1; k--) begin
            cand = IW'((int'(ptr) + k) % N);
            if (req_valid[cand]) pick = cand;
        end
    end

    assign handshake = (state == SEND) && req_valid[owner];
    assign req_ready = (state == SEND) ? (grant & req_valid) : '0;
    assign busy      = (state != IDLE);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            ptr       <= IW'(N - 1);
            owner     <= '0;
            grant     <= '0;
            last_q    <= 1'b0;
            burst_cnt <= '0;
            hold_cnt  <= '0;
            tx_data   <= 8'h00;
            tx_wr     <= 1'b0;
        end else begin
            tx_wr <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        owner     <= pick;
                        grant     <= ONE << pick;
                        burst_cnt <= '0;
                        hold_cnt  <= '0;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (handshake) begin
                        tx_data <= req_data[{owner, 3'b000} +: 8];
                        tx_wr   <= 1'b1;
                        last_q  <= req_last[owner];
                        if (burst_cnt != BW'(MAX_BURST)) burst_cnt <= burst_cnt + BW'(1);
                        state   <= WAIT;
                    end else begin
                        if (hold_cnt != HW'(HOLD_CYCLES)) hold_cnt <= hold_cnt + HW'(1);
                        // This idle cycle is the HOLD_CYCLES-th one: give the UART away.
                        if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
                            ptr   <= owner;
                            grant <= '0;
                            state <= IDLE;
                        end
                    end
                end
                WAIT: begin
                    if (tx_done) begin
                        if (last_q || burst_cnt == BW'(MAX_BURST)) begin
                            ptr   <= owner;
                            grant <= '0;
                            state <= IDLE;
                        end else begin
                            hold_cnt <= '0;
                            state    <= SEND;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queues, a 10-cycle UART model and a write log.
// dut_a carries the reduced burst/hold limits; dut_b keeps the defaults for the long pacing run.
module tb_uart_tx_arbiter;
    localparam int N = 4;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic           rst_n = 1'b0;
    logic           sel_b = 1'b0;
    logic           rst_a, rst_b;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data  = '0;
    logic [N-1:0]   req_last  = '0;
    logic           tx_done   = 1'b0;

    logic [N-1:0] ready_a, grant_a, ready_b, grant_b;
    logic         busy_a, busy_b, tx_wr_a, tx_wr_b;
    logic [7:0]   tx_data_a, tx_data_b;
    logic [N-1:0] ready_m, grant_m;
    logic         busy_m, tx_wr_m;
    logic [7:0]   tx_data_m;

    assign rst_a     = rst_n & ~sel_b;
    assign rst_b     = rst_n & sel_b;
    assign ready_m   = sel_b ? ready_b : ready_a;
    assign grant_m   = sel_b ? grant_b : grant_a;
    assign busy_m    = sel_b ? busy_b : busy_a;
    assign tx_wr_m   = sel_b ? tx_wr_b : tx_wr_a;
    assign tx_data_m = sel_b ? tx_data_b : tx_data_a;

    uart_tx_arbiter #(.N(N), .MAX_BURST(4), .HOLD_CYCLES(8)) dut_a (
        .sys_clk(sys_clk), .sys_rst_n(rst_a), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(ready_a), .grant(grant_a), .busy(busy_a),
        .tx_data(tx_data_a), .tx_wr(tx_wr_a), .tx_done(tx_done));

    uart_tx_arbiter #(.N(N), .MAX_BURST(16), .HOLD_CYCLES(255)) dut_b (
        .sys_clk(sys_clk), .sys_rst_n(rst_b), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(ready_b), .grant(grant_b), .busy(busy_b),
        .tx_data(tx_data_b), .tx_wr(tx_wr_b), .tx_done(tx_done));

    int errors = 0;
    int checks = 0;

    logic [8:0]   rq[N][$];
    logic [N-1:0] hs_q = '0;
    logic [3:0]   ghist[$];
    logic [7:0]   wr_data[$];
    logic [3:0]   wr_gnt[$];
    int           wr_cyc[$];
    int           done_cyc[$];
    int           uart_cnt = 0;
    int           viol = 0;
    logic         prev_wr = 1'b0;
    logic         outstanding = 1'b0;

    always @(posedge sys_clk) hs_q <= ready_m;

    // Mid-cycle: log registered outputs, then drive this cycle's inputs.
    always @(negedge sys_clk) begin : model
        int cyc;
        cyc = ghist.size();
        ghist.push_back(grant_m);
        if (tx_wr_m === 1'b1) begin
            if (prev_wr || outstanding) viol++;
            wr_data.push_back(tx_data_m);
            wr_gnt.push_back(grant_m);
            wr_cyc.push_back(cyc);
            outstanding = 1'b1;
        end
        prev_wr = (tx_wr_m === 1'b1);
        tx_done = 1'b0;
        if (uart_cnt > 0) begin
            uart_cnt--;
            if (uart_cnt == 0) begin
                tx_done = 1'b1;
                outstanding = 1'b0;
                done_cyc.push_back(cyc);
            end
        end
        if (tx_wr_m === 1'b1) uart_cnt = 10;
        for (int i = 0; i < N; i++) begin
            if (hs_q[i] === 1'b1 && rq[i].size() > 0) void'(rq[i].pop_front());
            req_valid[i] = (rq[i].size() > 0);
            if (rq[i].size() > 0) {req_last[i], req_data[8*i +: 8]} = rq[i][0];
            else {req_last[i], req_data[8*i +: 8]} = 9'h000;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic push(input int r, input logic last, input logic [7:0] d);
        rq[r].push_back({last, d});
    endtask

    task automatic wait_quiet(input int budget, input string name);
        int spent = 0;
        while ((busy_m !== 1'b0 || uart_cnt != 0 || rq[0].size() != 0 || rq[1].size() != 0 ||
                rq[2].size() != 0 || rq[3].size() != 0) && spent < budget) begin
            tick(1);
            spent++;
        end
        checks++;
        if (spent >= budget) begin
            errors++;
            $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, budget);
        end
        tick(3);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        checks += 5;
        if (grant_m !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b want 0000", grant_m); end
        if (ready_m !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", ready_m); end
        if (tx_wr_m !== 1'b0) begin errors++; $display("FAIL reset_tx_wr: got %b want 0", tx_wr_m); end
        if (tx_data_m !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data_m); end
        if (busy_m !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_m); end
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_single();
        logic [7:0] exp_d[3];
        int base, dbase, c0, d3, bad;
        exp_d = '{8'h41, 8'h42, 8'h43};
        base = wr_data.size(); dbase = done_cyc.size(); c0 = ghist.size();
        push(1, 1'b0, 8'h41); push(1, 1'b0, 8'h42); push(1, 1'b1, 8'h43);
        wait_quiet(200, "single");
        checks++;
        if (wr_data.size() - base != 3 || done_cyc.size() - dbase != 3) begin
            errors++;
            $display("FAIL single_count: got %0d writes %0d dones, want 3 and 3",
                     wr_data.size() - base, done_cyc.size() - dbase);
            return;
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (wr_data[base+k] !== exp_d[k]) begin
                errors++; $display("FAIL single_byte%0d: got %h want %h", k, wr_data[base+k], exp_d[k]);
            end
        end
        checks++;
        if (wr_cyc[base] - c0 != 2) begin
            errors++; $display("FAIL single_latency: got %0d cycles want 2", wr_cyc[base] - c0);
        end
        d3 = done_cyc[dbase+2];
        bad = 0;
        for (int c = c0 + 1; c <= d3; c++) if (ghist[c] !== 4'b0010) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL single_grant_held: %0d cycles off 0010, want 0", bad); end
        checks++;
        if (ghist[d3+1] !== 4'b0000) begin
            errors++; $display("FAIL single_release: got %b want 0000", ghist[d3+1]);
        end
    endtask

    task automatic test_round_robin();
        logic [11:0] exp_e[8];
        int base;
        exp_e = '{{4'b0001, 8'h10}, {4'b0001, 8'h11}, {4'b0100, 8'h20}, {4'b0100, 8'h21},
                  {4'b0001, 8'h12}, {4'b0001, 8'h13}, {4'b0100, 8'h22}, {4'b0100, 8'h23}};
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        base = wr_data.size();
        push(0, 1'b0, 8'h10); push(0, 1'b1, 8'h11);
        push(2, 1'b0, 8'h20); push(2, 1'b1, 8'h21);
        wait_quiet(300, "rr_first");
        push(0, 1'b0, 8'h12); push(0, 1'b1, 8'h13);
        push(2, 1'b0, 8'h22); push(2, 1'b1, 8'h23);
        wait_quiet(300, "rr_second");
        checks++;
        if (wr_data.size() - base != 8) begin
            errors++; $display("FAIL rr_count: got %0d writes want 8", wr_data.size() - base);
            return;
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if ({wr_gnt[base+k], wr_data[base+k]} !== exp_e[k]) begin
                errors++;
                $display("FAIL rr_entry%0d: got grant %b byte %h want grant %b byte %h", k,
                         wr_gnt[base+k], wr_data[base+k], exp_e[k][11:8], exp_e[k][7:0]);
            end
        end
    endtask

    task automatic test_burst();
        logic [11:0] exp_e[8];
        int base;
        exp_e = '{{4'b1000, 8'h30}, {4'b1000, 8'h31}, {4'b1000, 8'h32}, {4'b1000, 8'h33},
                  {4'b0010, 8'h50}, {4'b0010, 8'h51}, {4'b1000, 8'h34}, {4'b1000, 8'h35}};
        base = wr_data.size();
        for (int k = 0; k < 6; k++) push(3, (k == 5), 8'h30 + 8'(k));
        tick(3);
        push(1, 1'b0, 8'h50); push(1, 1'b1, 8'h51);
        wait_quiet(400, "burst");
        checks++;
        if (wr_data.size() - base != 8) begin
            errors++; $display("FAIL burst_count: got %0d writes want 8", wr_data.size() - base);
            return;
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if ({wr_gnt[base+k], wr_data[base+k]} !== exp_e[k]) begin
                errors++;
                $display("FAIL burst_entry%0d: got grant %b byte %h want grant %b byte %h", k,
                         wr_gnt[base+k], wr_data[base+k], exp_e[k][11:8], exp_e[k][7:0]);
            end
        end
    endtask

    task automatic test_hold();
        int base, dbase, d, bad;
        base = wr_data.size(); dbase = done_cyc.size();
        push(0, 1'b0, 8'h60);
        tick(5);
        push(1, 1'b1, 8'h70);
        wait_quiet(400, "hold");
        checks++;
        if (wr_data.size() - base != 2 || done_cyc.size() - dbase != 2) begin
            errors++;
            $display("FAIL hold_count: got %0d writes %0d dones want 2 and 2",
                     wr_data.size() - base, done_cyc.size() - dbase);
            return;
        end
        checks++;
        if ({wr_gnt[base], wr_data[base], wr_gnt[base+1], wr_data[base+1]} !==
            {4'b0001, 8'h60, 4'b0010, 8'h70}) begin
            errors++;
            $display("FAIL hold_bytes: got %b/%h %b/%h want 0001/60 0010/70",
                     wr_gnt[base], wr_data[base], wr_gnt[base+1], wr_data[base+1]);
        end
        d = done_cyc[dbase];
        bad = 0;
        for (int c = d + 1; c <= d + 8; c++) if (ghist[c] !== 4'b0001) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL hold_grant_kept: %0d cycles off 0001, want 0", bad); end
        checks++;
        if (ghist[d+9] !== 4'b0000) begin
            errors++; $display("FAIL hold_release: got %b want 0000 at SEND+8", ghist[d+9]);
        end
        checks++;
        if (ghist[d+10] !== 4'b0010) begin
            errors++; $display("FAIL hold_next_owner: got %b want 0010", ghist[d+10]);
        end
    endtask

    task automatic test_reset_mid();
        int base, dbase, spent, r0, bad;
        base = wr_data.size(); dbase = done_cyc.size();
        push(2, 1'b0, 8'h80); push(2, 1'b1, 8'h81);
        spent = 0;
        while (wr_data.size() == base && spent < 20) begin tick(1); spent++; end
        checks++;
        if (wr_data.size() == base) begin
            errors++; $display("FAIL rstmid_first_wr: no tx_wr within 20 cycles, want one");
            return;
        end
        tick(3);
        rq[2].delete();
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        r0 = ghist.size();
        checks += 5;
        if (grant_m !== 4'b0000) begin errors++; $display("FAIL rstmid_grant: got %b want 0000", grant_m); end
        if (ready_m !== 4'b0000) begin errors++; $display("FAIL rstmid_ready: got %b want 0000", ready_m); end
        if (tx_wr_m !== 1'b0) begin errors++; $display("FAIL rstmid_tx_wr: got %b want 0", tx_wr_m); end
        if (tx_data_m !== 8'h00) begin errors++; $display("FAIL rstmid_tx_data: got %h want 00", tx_data_m); end
        if (busy_m !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy_m); end
        tick(20);
        checks++;
        if (done_cyc.size() - dbase != 1) begin
            errors++; $display("FAIL rstmid_stray_done: got %0d dones want 1", done_cyc.size() - dbase);
        end
        checks++;
        if (wr_data.size() - base != 1) begin
            errors++; $display("FAIL rstmid_no_wr: got %0d writes want 1", wr_data.size() - base);
        end
        bad = 0;
        for (int c = r0; c < ghist.size(); c++) if (ghist[c] !== 4'b0000) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL rstmid_no_grant: %0d granted cycles want 0", bad); end
    endtask

    task automatic test_back_to_back();
        int base, dbase, c0;
        sel_b = 1'b1;
        tick(2);
        base = wr_data.size(); dbase = done_cyc.size(); c0 = ghist.size();
        for (int k = 0; k < 5; k++) push(1, (k == 4), 8'h90 + 8'(k));
        wait_quiet(400, "b2b");
        checks++;
        if (wr_data.size() - base != 5 || done_cyc.size() - dbase != 5) begin
            errors++;
            $display("FAIL b2b_count: got %0d writes %0d dones want 5 and 5",
                     wr_data.size() - base, done_cyc.size() - dbase);
            return;
        end
        checks++;
        if (wr_cyc[base] - c0 != 2) begin
            errors++; $display("FAIL b2b_latency: got %0d want 2", wr_cyc[base] - c0);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({wr_gnt[base+k], wr_data[base+k]} !== {4'b0010, 8'h90 + 8'(k)}) begin
                errors++;
                $display("FAIL b2b_byte%0d: got grant %b byte %h want 0010 %h", k,
                         wr_gnt[base+k], wr_data[base+k], 8'h90 + 8'(k));
            end
        end
        for (int k = 1; k < 5; k++) begin
            checks++;
            if (wr_cyc[base+k] - done_cyc[dbase+k-1] != 2) begin
                errors++;
                $display("FAIL b2b_gap%0d: tx_wr %0d cycles after tx_done want 2", k,
                         wr_cyc[base+k] - done_cyc[dbase+k-1]);
            end
        end
        checks++;
        if (viol != 0) begin
            errors++; $display("FAIL pacing: %0d writes while busy or back-to-back, want 0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_burst();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

endmodule
